// File: rtl/alu_issuer.sv
// alu_issuer: single-outstanding command issuer for an external combinational ALU.
// Operands are held stable for SETTLE_CYCLES, then the result is captured and handed back.
`timescale 1ns/1ps
module alu_issuer #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   input  logic       cmd_use_acc,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_opcode,
   input  logic [7:0] alu_y,
   input  logic       alu_carry,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_y,
   output logic       rsp_carry,
   output logic [7:0] acc,
   output logic [7:0] op_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   state_t     r_state;
   logic       r_cmd_ready;
   logic       r_rsp_valid;
   logic [7:0] r_alu_a;
   logic [7:0] r_alu_b;
   logic [3:0] r_alu_opcode;
   logic [7:0] r_rsp_y;
   logic       r_rsp_carry;
   logic [7:0] r_acc;
   logic [7:0] r_op_count;
   logic [3:0] r_settle_cnt;

   logic       w_accept;
   logic       w_capture;

   // cmd_ready is a registered copy of (state == IDLE), so acceptance never depends combinationally on cmd_valid
   assign w_accept  = cmd_valid & r_cmd_ready;
   assign w_capture = (r_state == DRIVE) && (r_settle_cnt == 4'd1);

   // Issue, settle and respond sequencing; every output comes straight from a register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cmd_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_alu_a      <= 8'd0;
         r_alu_b      <= 8'd0;
         r_alu_opcode <= 4'd0;
         r_rsp_y      <= 8'd0;
         r_rsp_carry  <= 1'b0;
         r_acc        <= 8'd0;
         r_op_count   <= 8'd0;
         r_settle_cnt <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_alu_opcode <= cmd_op;
                  r_alu_b      <= cmd_b;
                  r_alu_a      <= cmd_use_acc ? r_acc : cmd_a;
                  r_settle_cnt <= SETTLE_INIT;
                  r_cmd_ready  <= 1'b0;
                  r_state      <= DRIVE;
               end
            end
            DRIVE: begin
               r_settle_cnt <= r_settle_cnt - 4'd1;
               if (w_capture) begin
                  r_rsp_y     <= alu_y;
                  r_rsp_carry <= alu_carry;
                  r_acc       <= alu_y;
                  r_op_count  <= r_op_count + 8'd1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_cmd_ready  <= 1'b1;
               r_rsp_valid  <= 1'b0;
               r_settle_cnt <= 4'd0;
            end
         endcase
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign rsp_valid  = r_rsp_valid;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_opcode = r_alu_opcode;
   assign rsp_y      = r_rsp_y;
   assign rsp_carry  = r_rsp_carry;
   assign acc        = r_acc;
   assign op_count   = r_op_count;

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, legal range 1..15: number of cycles ALU inputs are held stable before the result is sampled.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  issuer can accept a command.
REQ-006 cmd_op  input  4  ALU opcode to issue.
REQ-007 cmd_a  input  8  operand A.
REQ-008 cmd_b  input  8  operand B.
REQ-009 cmd_use_acc  input  1  when 1, the accumulator replaces cmd_a as operand A.
REQ-010 alu_a  output  8  registered operand A driven to the ALU.
REQ-011 alu_b  output  8  registered operand B driven to the ALU.
REQ-012 alu_opcode  output  4  registered opcode driven to the ALU.
REQ-013 alu_y  input  8  ALU result.
REQ-014 alu_carry  input  1  ALU carry out.
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  consumer accepts the result.
REQ-017 rsp_y  output  8  captured result.
REQ-018 rsp_carry  output  1  captured carry.
REQ-019 acc  output  8  accumulator, equal to the last captured rsp_y.
REQ-020 op_count  output  8  count of completed operations.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, DRIVE, RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE and SHALL be a registered state decode, not a function of cmd_valid.
REQ-023 Command acceptance is cmd_valid & cmd_ready at a rising edge; at that edge alu_opcode<=cmd_op, alu_b<=cmd_b, alu_a<=(cmd_use_acc ? acc : cmd_a), settle counter<=SETTLE_CYCLES, and the state goes IDLE->DRIVE.
REQ-024 In DRIVE the settle counter SHALL decrement by 1 each cycle; on the edge where the counter equals 1, rsp_y<=alu_y, rsp_carry<=alu_carry, acc<=alu_y, op_count<=op_count+1, and the state goes DRIVE->RESP.
REQ-025 Latency: for acceptance at edge k, capture SHALL occur at edge k+SETTLE_CYCLES and rsp_valid SHALL be 1 from that edge onward.
REQ-026 rsp_valid SHALL be 1 only in RESP; rsp_y and rsp_carry SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-027 On rsp_valid & rsp_ready at an edge, the state SHALL go RESP->IDLE; the next command can be accepted no earlier than the following edge (one-cycle bubble).
REQ-028 alu_a, alu_b and alu_opcode SHALL hold their last issued values in IDLE, DRIVE and RESP; they change only on acceptance.
REQ-029 cmd_valid while not in IDLE SHALL be ignored without state change; cmd_* inputs are sampled only at the acceptance edge.
REQ-030 op_count SHALL wrap from 255 to 0 without a flag.
REQ-031 acc SHALL be updated at capture regardless of cmd_use_acc; cmd_use_acc with acc=0 after reset SHALL issue alu_a=0.
REQ-032 Outside the capture edge, alu_y and alu_carry SHALL have no effect on any register.

Reset
REQ-033 rst_n=0 SHALL immediately force: state IDLE, cmd_ready=1 once released, rsp_valid=0, alu_a=alu_b=0, alu_opcode=0, rsp_y=0, rsp_carry=0, acc=0, op_count=0, settle counter=0.
REQ-034 Reset asserted in DRIVE or RESP SHALL abort the operation: no capture, no op_count increment, no rsp_valid pulse after release.
REQ-035 The first rising edge after rst_n deassertion SHALL be able to accept a command.

Verification
REQ-036 SETTLE_CYCLES=1, bench ALU model returns alu_y=8'h5A, alu_carry=1; issue cmd_op=4'h0, a=8'h12, b=8'h34 with rsp_ready=1 -> rsp_valid at edge k+1 for one cycle, rsp_y=8'h5A, rsp_carry=1, acc=8'h5A, op_count=1, cmd_ready high again at edge k+2.
REQ-037 SETTLE_CYCLES=3, rsp_ready held 0 for 5 cycles after rsp_valid, with alu_y changed each cycle -> rsp_y stays the value at edge k+3, cmd_ready=0 throughout, cmd_valid pulses ignored.
REQ-038 Back-to-back commands, second with cmd_use_acc=1 and cmd_a=8'hFF, after first result 8'h77 -> second issue shows alu_a=8'h77, not 8'hFF.
REQ-039 256 completed operations from reset -> op_count reads 0 and the 257th operation reads 1.
REQ-040 rst_n pulsed low during DRIVE (SETTLE_CYCLES=4, at edge k+2) -> all outputs zero immediately, no rsp_valid afterward, op_count=0, next command accepted normally.
REQ-041 cmd_valid held high continuously with rsp_ready=1 -> one accepted command every SETTLE_CYCLES+2 cycles, each alu_* change aligned to its acceptance edge.
